// File: rtl/mmss_timer_ctrl.sv
// Minutes:seconds stopwatch / countdown timer with one-second prescaler and control FSM.
// Optional lap capture (lap, lap_min, lap_sec, lap_valid) is built when MMSS_LAP_EN is defined.
module mmss_timer_ctrl #(
  parameter int unsigned TICK_DIV  = 100_000_000,
  parameter int unsigned MIN_WIDTH = 7,
  parameter int unsigned MAX_MIN   = 99
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 pause,
  input  logic                 clear,
  input  logic                 set_en,
  input  logic [MIN_WIDTH-1:0] set_min,
  input  logic [5:0]           set_sec,
  input  logic                 mode,
`ifdef MMSS_LAP_EN
  input  logic                 lap,
  output logic [MIN_WIDTH-1:0] lap_min,
  output logic [5:0]           lap_sec,
  output logic                 lap_valid,
`endif
  output logic [MIN_WIDTH-1:0] minutes,
  output logic [5:0]           seconds,
  output logic                 running,
  output logic                 expired,
  output logic                 alarm
);

  localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]        PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [MIN_WIDTH-1:0] MAX_MIN_V  = MIN_WIDTH'(MAX_MIN);
  localparam logic [5:0]           SEC_MAX    = 6'd59;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_PAUSE   = 2'd2,
    S_EXPIRED = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [MIN_WIDTH-1:0] min_d;
  logic [5:0]           sec_d;
  logic [PW-1:0]        presc_q, presc_d;
  logic                 mode_q, mode_d;
  logic                 expired_d;
  logic [MIN_WIDTH-1:0] set_min_clamp;
  logic [5:0]           set_sec_clamp;

  // Preset values are saturated to the largest displayable time.
  assign set_min_clamp = (set_min > MAX_MIN_V) ? MAX_MIN_V : set_min;
  assign set_sec_clamp = (set_sec > SEC_MAX)   ? SEC_MAX   : set_sec;

  // State register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      minutes <= '0;
      seconds <= '0;
      presc_q <= '0;
      mode_q  <= 1'b1;
      expired <= 1'b0;
      running <= 1'b0;
      alarm   <= 1'b0;
    end else begin
      state_q <= state_d;
      minutes <= min_d;
      seconds <= sec_d;
      presc_q <= presc_d;
      mode_q  <= mode_d;
      expired <= expired_d;
      running <= (state_d == S_RUN);
      alarm   <= (state_d == S_EXPIRED);
    end
  end

  // Next-state, time and prescaler logic; clear overrides every other command.
  always_comb begin
    state_d   = state_q;
    min_d     = minutes;
    sec_d     = seconds;
    presc_d   = presc_q;
    mode_d    = mode_q;
    expired_d = 1'b0;

    if (clear) begin
      state_d = S_IDLE;
      min_d   = '0;
      sec_d   = '0;
      presc_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (set_en) begin
            min_d   = set_min_clamp;
            sec_d   = set_sec_clamp;
            presc_d = '0;
          end else if (start) begin
            mode_d  = mode;
            presc_d = '0;
            // Counting down from 00:00 would expire immediately, so refuse to start.
            if (mode || (minutes != '0) || (seconds != '0)) begin
              state_d = S_RUN;
            end
          end
        end

        S_RUN: begin
          if (pause) begin
            state_d = S_PAUSE;
          end else if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            if (mode_q) begin
              if ((minutes == MAX_MIN_V) && (seconds == SEC_MAX)) begin
                expired_d = 1'b1;
                state_d   = S_EXPIRED;
              end else if (seconds == SEC_MAX) begin
                sec_d = '0;
                min_d = minutes + MIN_WIDTH'(1);
              end else begin
                sec_d = seconds + 6'd1;
              end
            end else begin
              if ((minutes == '0) && (seconds <= 6'd1)) begin
                sec_d     = '0;
                expired_d = 1'b1;
                state_d   = S_EXPIRED;
              end else if (seconds == '0) begin
                sec_d = SEC_MAX;
                min_d = minutes - MIN_WIDTH'(1);
              end else begin
                sec_d = seconds - 6'd1;
              end
            end
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end

        S_PAUSE: begin
          if (set_en) begin
            state_d = S_IDLE;
            min_d   = set_min_clamp;
            sec_d   = set_sec_clamp;
            presc_d = '0;
          end else if (start) begin
            state_d = S_RUN;
          end
        end

        S_EXPIRED: begin
          if (set_en) begin
            state_d = S_IDLE;
            min_d   = set_min_clamp;
            sec_d   = set_sec_clamp;
            presc_d = '0;
          end
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

`ifdef MMSS_LAP_EN
  // Lap capture samples the displayed (pre-tick) time while running.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      lap_min   <= '0;
      lap_sec   <= '0;
      lap_valid <= 1'b0;
    end else if ((state_q == S_RUN) && lap) begin
      lap_min   <= minutes;
      lap_sec   <= seconds;
      lap_valid <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mmss_timer_ctrl.sv
// Scoreboard bench for mmss_timer_ctrl: directed scenarios plus randomized commands,
// checked against a total-seconds reference model. Lap ports are covered when MMSS_LAP_EN is defined.
module tb_mmss_timer_ctrl;

  localparam int unsigned TD = 4;
  localparam int unsigned MW = 7;
  localparam int unsigned MM = 99;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_EXP   = 3;

  typedef struct {
    int mins;
    int secs;
    bit run;
    bit exp;
    bit alm;
    int lmin;
    int lsec;
    bit lv;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst, start, pause, clear, set_en, mode;
  logic [MW-1:0] set_min;
  logic [5:0]    set_sec;
  logic [MW-1:0] minutes;
  logic [5:0]    seconds;
  logic          running, expired, alarm;
`ifdef MMSS_LAP_EN
  logic          lap;
  logic [MW-1:0] lap_min;
  logic [5:0]    lap_sec;
  logic          lap_valid;
`endif

  exp_t  q[$];
  string tq[$];
  int    total = 0;
  int    bad = 0;

  // reference model: time kept as total seconds, prescaler as a cycle phase
  int m_st = M_IDLE;
  int m_t = 0;
  int m_ph = 0;
  int m_mode = 1;
  int m_lmin = 0;
  int m_lsec = 0;
  bit m_lv = 1'b0;

  mmss_timer_ctrl #(.TICK_DIV(TD), .MIN_WIDTH(MW), .MAX_MIN(MM)) dut (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .clear(clear),
    .set_en(set_en), .set_min(set_min), .set_sec(set_sec), .mode(mode),
`ifdef MMSS_LAP_EN
    .lap(lap), .lap_min(lap_min), .lap_sec(lap_sec), .lap_valid(lap_valid),
`endif
    .minutes(minutes), .seconds(seconds), .running(running),
    .expired(expired), .alarm(alarm)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, advance the model, queue the expected post-edge outputs.
  task automatic step(input string tag, input bit r, input bit c, input bit se,
                      input bit st, input bit pa, input bit md,
                      input int smin, input int ssec, input bit lp);
    exp_t e;
    bit   pulse;
    rst = r; clear = c; set_en = se; start = st; pause = pa; mode = md;
    set_min = MW'(smin);
    set_sec = 6'(ssec);
`ifdef MMSS_LAP_EN
    lap = lp;
`endif
    if (r || c) begin
      m_lmin = 0; m_lsec = 0; m_lv = 1'b0;
    end else if (m_st == M_RUN && lp) begin
      m_lmin = m_t / 60; m_lsec = m_t % 60; m_lv = 1'b1;
    end
    pulse = 1'b0;
    if (r) begin
      m_st = M_IDLE; m_t = 0; m_ph = 0; m_mode = 1;
    end else if (c) begin
      m_st = M_IDLE; m_t = 0; m_ph = 0;
    end else if (se && m_st != M_RUN) begin
      m_t  = ((smin > int'(MM)) ? int'(MM) : smin) * 60 + ((ssec > 59) ? 59 : ssec);
      m_ph = 0; m_st = M_IDLE;
    end else begin
      case (m_st)
        M_IDLE: if (st) begin
          m_mode = md; m_ph = 0;
          if (md || m_t != 0) m_st = M_RUN;
        end
        M_RUN: if (pa) m_st = M_PAUSE;
          else if (m_ph == int'(TD) - 1) begin
            m_ph = 0;
            if (m_mode != 0) begin
              if (m_t == int'(MM) * 60 + 59) begin pulse = 1'b1; m_st = M_EXP; end
              else m_t++;
            end else begin
              m_t--;
              if (m_t == 0) begin pulse = 1'b1; m_st = M_EXP; end
            end
          end else m_ph++;
        M_PAUSE: if (st) m_st = M_RUN;
        default: ;
      endcase
    end
    e.mins = m_t / 60; e.secs = m_t % 60;
    e.run = (m_st == M_RUN); e.alm = (m_st == M_EXP); e.exp = pulse;
    e.lmin = m_lmin; e.lsec = m_lsec; e.lv = m_lv;
    q.push_back(e);
    tq.push_back(tag);
    @(negedge clk);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: one output presentation per clock, compared against the queue head.
  initial begin
    exp_t  e;
    string tg;
    bit    ok;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e  = q.pop_front();
        tg = tq.pop_front();
        ok = (int'(minutes) == e.mins) && (int'(seconds) == e.secs) &&
             (running == e.run) && (expired == e.exp) && (alarm == e.alm);
`ifdef MMSS_LAP_EN
        ok = ok && (int'(lap_min) == e.lmin) && (int'(lap_sec) == e.lsec) && (lap_valid == e.lv);
`endif
        total++;
        if (!ok) begin
          bad++;
          $display("FAIL %s t=%0t got %0d:%0d run=%0b exp=%0b alm=%0b, want %0d:%0d run=%0b exp=%0b alm=%0b lap %0d:%0d v%0b",
                   tg, $time, minutes, seconds, running, expired, alarm,
                   e.mins, e.secs, e.run, e.exp, e.alm, e.lmin, e.lsec, e.lv);
        end
      end
    end
  end

  initial begin
    int smin, ssec;
    step("reset", 1, 0, 0, 0, 0, 0, 0, 0, 0);
    step("reset", 1, 0, 0, 0, 0, 1, 0, 0, 0);
    idle("reset_idle", 2);

    // up count from 00:00 through 01:00
    step("t1_start", 0, 0, 0, 1, 0, 1, 0, 0, 0);
    for (int i = 0; i < 242; i++) step("t1_up", 0, 0, 0, 0, 0, 0, 0, 0, (i % 37) == 5);

    // countdown 00:03 to expiry, then hold
    step("t2_clear", 0, 1, 0, 0, 0, 0, 0, 0, 0);
    step("t2_set", 0, 0, 1, 0, 0, 0, 0, 3, 0);
    step("t2_start", 0, 0, 0, 1, 0, 0, 0, 0, 0);
    idle("t2_down", 24);

    // 02:00 down one tick -> 01:59
    step("t3_set", 0, 0, 1, 0, 0, 1, 2, 0, 0);
    step("t3_start", 0, 0, 0, 1, 0, 0, 0, 0, 0);
    idle("t3_down", 6);

    // pause at prescaler 2, resume keeps phase
    step("t4_clear", 0, 1, 0, 0, 0, 0, 0, 0, 0);
    step("t4_start", 0, 0, 0, 1, 0, 1, 0, 0, 0);
    idle("t4_run", 6);
    for (int i = 0; i < 10; i++) step("t4_pause", 0, 0, 0, 0, 1, i[0], 0, 0, 1);
    step("t4_resume", 0, 0, 0, 1, 1, 0, 0, 0, 0);
    idle("t4_after", 8);

    // saturated preset 99:59, up expiry, set_en ignored while running
    step("t5_set", 0, 0, 1, 0, 0, 0, 120, 75, 0);
    step("t5_start", 0, 0, 0, 1, 0, 1, 0, 0, 0);
    step("t5_setrun", 0, 0, 1, 0, 0, 0, 5, 5, 1);
    idle("t5_up", 8);
    step("t5_startexp", 0, 0, 0, 1, 0, 1, 0, 0, 0);
    step("t5_setexp", 0, 0, 1, 0, 0, 0, 0, 10, 0);
    idle("t5_idle", 2);

    // clear wins over set_en+start; rst from EXPIRED; down start at 00:00 refused
    step("t6_set", 0, 0, 1, 0, 0, 0, 10, 0, 0);
    step("t6_start", 0, 0, 0, 1, 0, 0, 0, 0, 0);
    idle("t6_run", 2);
    step("t6_clr", 0, 1, 1, 1, 0, 0, 7, 7, 1);
    idle("t6_idle", 2);
    step("t6_set2", 0, 0, 1, 0, 0, 0, 0, 2, 0);
    step("t6_start2", 0, 0, 0, 1, 0, 0, 0, 0, 0);
    idle("t6_down", 12);
    step("t6_rst", 1, 0, 1, 1, 0, 0, 3, 3, 0);
    idle("t6_post", 2);
    step("t6_zero", 0, 0, 0, 1, 0, 0, 0, 0, 0);
    idle("t6_zero_idle", 4);

    // randomized command mix
    for (int i = 0; i < 6000; i++) begin
      smin = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 127)) : int'($urandom_range(0, 1));
      ssec = int'($urandom_range(0, 63));
      if ($urandom_range(0, 9) == 0) begin smin = 99; ssec = int'($urandom_range(55, 63)); end
      step("rand", $urandom_range(0, 999) < 3, $urandom_range(0, 99) < 2,
           $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 8,
           $urandom_range(0, 99) < 4, 1'($urandom_range(0, 1)),
           smin, ssec, $urandom_range(0, 99) < 5);
    end
    idle("drain", 2);

    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expected entries left, want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
